// File: rtl/optest_pkg.sv
// Shared types and constants for the operator-test sweep block.
// Holds the FSM state enum, MISR polynomial, capture latency and index width.
package optest_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam int          CAP_LAT   = 2;
    localparam int          IDX_W     = 12;
    localparam int          CNT_W     = 13;

    function automatic logic [15:0] misr_step(
        input logic [15:0] s,
        input logic [7:0]  d
    );
        logic [15:0] fb;
        fb = s[15] ? MISR_POLY : 16'h0000;
        return {s[14:0], 1'b0} ^ fb ^ {8'h00, d};
    endfunction

endpackage

// File: rtl/optest_misr.sv
// 16-bit MISR compacting a stream of 8-bit results.
// Ports: clk, rst (sync), load (sig<=init), en (fold din), din, init, sig.
module optest_misr
    import optest_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [7:0]  din,
    input  logic [15:0] init,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= init;
        end else if (load) begin
            sig <= init;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/optest_sweep.sv
// Sweeps every {mode, a, b} vector into a registered shift stage and
// compacts the returned y values into a MISR signature.
// Ports: clk, rst (sync, active-high), start; vector outputs mode/u1/u2/
// s1/s2; y result input; busy, done, signature, count status outputs.
module optest_sweep
    import optest_pkg::*;
#(
    parameter int          MODE_LAST = 15,
    parameter logic [15:0] SIG_INIT  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [6:0]        mode,
    output logic [3:0]        u1,
    output logic [3:0]        u2,
    output logic signed [3:0] s1,
    output logic signed [3:0] s2,
    input  logic [7:0]        y,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic [12:0]       count
);

    localparam logic [3:0] M_LAST = 4'(MODE_LAST);
    localparam logic [IDX_W-1:0] IDX_LAST = {M_LAST, 8'hFF};

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               drn_q;
    logic               drn_d;
    logic               start_ok;
    logic               vec_on;
    logic [CAP_LAT-1:0] vld_q;
    logic               cap;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drn_d    = drn_q;
        start_ok = 1'b0;
        vec_on   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    start_ok = 1'b1;
                    idx_d    = '0;
                    vec_on   = 1'b1;
                end
            end
            RUN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DRAIN;
                    drn_d   = 1'b0;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    vec_on = 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles let the last vector clear the y pipeline.
                drn_d = 1'b1;
                if (drn_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cap = vld_q[CAP_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drn_q   <= 1'b0;
            vld_q   <= '0;
            cnt_q   <= '0;
            mode    <= '0;
            u1      <= '0;
            u2      <= '0;
            s1      <= '0;
            s2      <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drn_q   <= drn_d;
            if (start_ok) begin
                vld_q <= CAP_LAT'(1);
            end else begin
                vld_q <= {vld_q[CAP_LAT-2:0], vec_on};
            end
            if (start_ok) begin
                cnt_q <= '0;
            end else if (cap) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (vec_on) begin
                mode <= {3'b000, idx_d[11:8]};
                u1   <= idx_d[7:4];
                u2   <= idx_d[3:0];
                s1   <= idx_d[7:4];
                s2   <= idx_d[3:0];
            end else begin
                mode <= '0;
                u1   <= '0;
                u2   <= '0;
                s1   <= '0;
                s2   <= '0;
            end
        end
    end

    optest_misr u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (cap),
        .din  (y),
        .init (SIG_INIT),
        .sig  (signature)
    );

    assign count = cnt_q;
    assign busy  = (state_q == RUN) || (state_q == DRAIN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_optest_sweep.sv
// Directed bench for optest_sweep with a behavioural shift stage on y.
// A second instance uses SIG_INIT=0 with y tied low.
module tb_optest_sweep;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              hold42;
    logic [6:0]        mode;
    logic [3:0]        u1;
    logic [3:0]        u2;
    logic signed [3:0] s1;
    logic signed [3:0] s2;
    logic [7:0]        y;
    logic [7:0]        y_sh = 8'h00;
    logic              busy;
    logic              done;
    logic [15:0]       sig;
    logic [12:0]       cnt;

    logic [6:0]        mode0;
    logic [3:0]        u10;
    logic [3:0]        u20;
    logic signed [3:0] s10;
    logic signed [3:0] s20;
    logic              busy0;
    logic              done0;
    logic [15:0]       sig0;
    logic [12:0]       cnt0;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_sig;
    logic [15:0] sig_b;

    always #5 clk = ~clk;

    optest_sweep u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .u1        (u1),
        .u2        (u2),
        .s1        (s1),
        .s2        (s2),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .signature (sig),
        .count     (cnt)
    );

    optest_sweep #(
        .MODE_LAST (15),
        .SIG_INIT  (16'h0000)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode0),
        .u1        (u10),
        .u2        (u20),
        .s1        (s10),
        .s2        (s20),
        .y         (8'h00),
        .busy      (busy0),
        .done      (done0),
        .signature (sig0),
        .count     (cnt0)
    );

    function automatic logic [7:0] shf(
        input logic [3:0] m,
        input logic [3:0] ua,
        input logic [3:0] ub,
        input logic [3:0] sa,
        input logic [3:0] sb
    );
        logic [7:0]        r;
        logic signed [7:0] t;
        t = {{4{sa[3]}}, sa};
        case (m[1:0])
            2'd0:    r = {4'h0, ua} << ub[2:0];
            2'd1:    r = {ua, 4'h0} >> ub[2:0];
            2'd2:    r = t >>> sb[1:0];
            default: r = {ua, ub} ^ {m, m};
        endcase
        return r ^ {4'h0, m};
    endfunction

    always @(posedge clk) begin
        y_sh <= shf(mode[3:0], u1, u2, s1, s2);
    end

    assign y = hold42 ? 8'h42 : y_sh;

    function automatic logic [15:0] ref_sig();
        logic [15:0] s;
        logic [7:0]  d;
        s = 16'hFFFF;
        for (int m = 0; m < 16; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    d = shf(4'(m), 4'(a), 4'(b), 4'(a), 4'(b));
                    s = {s[14:0], 1'b0}
                      ^ (s[15] ? 16'h1021 : 16'h0000)
                      ^ {8'h00, d};
                end
            end
        end
        return s;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_sig = ref_sig();
        rst    = 1'b1;
        start  = 1'b0;
        hold42 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_sig", 32'(sig), 32'hFFFF);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_u1", 32'(u1), 32'd0);
        chk("rst_u2", 32'(u2), 32'd0);
        chk("rst_s1", 32'($unsigned(s1)), 32'd0);
        chk("rst_s2", 32'($unsigned(s2)), 32'd0);
        chk("rst_sig0", 32'(sig0), 32'd0);

        // First sweep: early vectors, first capture, then reset at edge 1000
        hold42 = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("e0_busy", 32'(busy), 32'd1);
        chk("e0_mode", 32'(mode), 32'd0);
        chk("e0_u1", 32'(u1), 32'd0);
        chk("e0_u2", 32'(u2), 32'd0);
        chk("e0_sig", 32'(sig), 32'hFFFF);
        tick();
        chk("e1_u2", 32'(u2), 32'd1);
        chk("e1_s2", 32'($unsigned(s2)), 32'd1);
        chk("e1_cnt", 32'(cnt), 32'd0);
        tick();
        chk("e2_sig", 32'(sig), 32'hEF9D);
        chk("e2_cnt", 32'(cnt), 32'd1);
        hold42 = 1'b0;
        repeat (14) tick();
        chk("e16_u1", 32'(u1), 32'd1);
        chk("e16_s1", 32'($unsigned(s1)), 32'd1);
        chk("e16_u2", 32'(u2), 32'd0);
        chk("e16_mode", 32'(mode), 32'd0);
        repeat (983) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_sig", 32'(sig), 32'hFFFF);
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_u1", 32'(u1), 32'd0);
        repeat (3) tick();
        chk("post_rst_cnt", 32'(cnt), 32'd0);
        chk("post_rst_sig", 32'(sig), 32'hFFFF);
        chk("post_rst_done", 32'(done), 32'd0);

        // Clean full sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4097) tick();
        chk("b_e4097_done", 32'(done), 32'd0);
        chk("b_e4097_busy", 32'(busy), 32'd1);
        tick();
        chk("b_done", 32'(done), 32'd1);
        chk("b_busy", 32'(busy), 32'd0);
        chk("b_cnt", 32'(cnt), 32'h1000);
        chk("b_sig", 32'(sig), 32'(exp_sig));
        chk("b_done0", 32'(done0), 32'd1);
        chk("b_busy0", 32'(busy0), 32'd0);
        chk("b_cnt0", 32'(cnt0), 32'h1000);
        chk("b_sig0", 32'(sig0), 32'd0);
        sig_b = sig;
        repeat (5) tick();
        chk("b_hold_done", 32'(done), 32'd1);
        chk("b_hold_mode", 32'(mode), 32'd0);
        chk("b_hold_cnt", 32'(cnt), 32'h1000);

        // Sweep from DONE with start pulses during RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_done_clr", 32'(done), 32'd0);
        chk("c_busy", 32'(busy), 32'd1);
        chk("c_cnt_clr", 32'(cnt), 32'd0);
        chk("c_sig_init", 32'(sig), 32'hFFFF);
        repeat (99) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_e100_busy", 32'(busy), 32'd1);
        repeat (1900) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_e2001_mode", 32'(mode), 32'd7);
        chk("c_e2001_u1", 32'(u1), 32'd13);
        chk("c_e2001_u2", 32'(u2), 32'd1);
        chk("c_e2001_s1", 32'($unsigned(s1)), 32'd13);
        chk("c_e2001_s2", 32'($unsigned(s2)), 32'd1);
        chk("c_e2001_cnt", 32'(cnt), 32'd2000);
        repeat (2096) tick();
        chk("c_e4097_done", 32'(done), 32'd0);
        tick();
        chk("c_done", 32'(done), 32'd1);
        chk("c_cnt", 32'(cnt), 32'h1000);
        chk("c_sig_same", 32'(sig), 32'(sig_b));
        chk("c_sig_ref", 32'(sig), 32'(exp_sig));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
